glyph_matcher: RTL
==================

Name: glyph_matcher

Overview:
Reader and initiator on the glyph-ROM row interface. After a start pulse it sweeps row addresses across a captured 16x16 user bitmap and across each digit template ROM. It scores every template by counting matching pixels and reports the best-scoring digit. It sits between the drawing-capture RAM and the result and operator logic of the number-recognition datapath.

Parameters:
NUM_TMPL, 10, number of digit templates scanned (indices 0..NUM_TMPL-1, max 16)
MIN_SCORE, 200, minimum matching-pixel count for a valid recognition (0..256)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a match; sampled only in IDLE
cap_addr  out  4  row address to capture bitmap memory
cap_row  in  16  [0:15] captured row; combinational, same-cycle response to cap_addr
tmpl_sel  out  4  template (digit) select to ROM bank
tmpl_addr  out  4  row address to template ROM
tmpl_row  in  16  [0:15] template row; combinational, same-cycle response to tmpl_sel/tmpl_addr
busy  out  1  high while scanning
done  out  1  one-cycle pulse when result registers update
digit  out  4  best-matching template index
score  out  9  matching-pixel count of best template (0..256)
valid  out  1  score >= MIN_SCORE for the last completed match

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE; busy=0, done=0, digit=0, score=0, valid=0.
  - cap_addr=0, tmpl_sel=0, tmpl_addr=0.
  - Internal accumulator, best score and best index all 0.
- States:
  - IDLE -> SCAN on start=1. On entry: d=0, r=0, acc=0, best_score=0, best_idx=0.
  - SCAN: one row per cycle. Outputs cap_addr=r, tmpl_addr=r, tmpl_sel=d, all driven from registered counters.
    - Row score: pop = popcount(~(cap_row ^ tmpl_row)), width 5 (0..16).
    - r<15: acc <= acc + pop, r <= r+1.
    - r=15: total = acc + pop (9 bits, max 256).
      - If total > best_score (strict), then best_score <= total and best_idx <= d. Ties keep the lower index; template 0 always wins over the initial 0.
      - acc <= 0, r <= 0, d <= d+1.
      - If d = NUM_TMPL-1, go to DONE.
  - DONE: digit <= best_idx, score <= best_score, valid <= (best_score >= MIN_SCORE), done=1 for exactly this cycle, then IDLE.
- busy is high in SCAN and DONE, low in IDLE.
- Outside SCAN, cap_addr, tmpl_sel and tmpl_addr return to 0.
- Latency: with start sampled in cycle 0, SCAN occupies cycles 1..16*NUM_TMPL and done is high in cycle 16*NUM_TMPL+1. For the default, done is high in cycle 161.
- start while busy is ignored, with no queuing. start in the same cycle as DONE is also ignored. A new start may be accepted in the first IDLE cycle.
- digit, score and valid hold their values until the next DONE. They do not change during a new scan.
- Reset asserted mid-scan aborts immediately to reset values. No done pulse is issued.
- Bit order: index 0 of [0:15] is the leftmost pixel. Popcount is order-independent, but cap_row and tmpl_row must use the same convention.

Decomposition:
- Shared package glyph_pkg:
  - GLYPH_W=16, GLYPH_H=16.
  - State enum {IDLE, SCAN, DONE}.
  - Score width constant SCORE_W=9.
- One sub-module, row_match16: combinational XNOR plus 16-bit popcount giving a 5-bit result. It is reused by future template-editing logic.

Test Plan:
1. Capture = exact copy of template 5; other templates differ in at least 40 pixels. Pulse start -> done at cycle 161, digit=5, score=256, valid=1.
2. Capture all-zero; templates with ones-counts 120/90/… where template 3 has the fewest ones (60). Expect digit=3, score=196, valid=0 (MIN_SCORE=200).
3. Templates 2 and 7 identical to capture, both scoring 256. Expect digit=2 (tie keeps lower index).
4. start pulsed at cycles 0, 50 and 161 -> only the cycle-0 start is accepted. busy stays high cycles 1..161 and exactly one done pulse occurs. A start at cycle 162 is accepted and gives done at 323.
5. Assert rst_n=0 at cycle 80 of a scan -> all outputs 0 immediately, no done pulse. A subsequent start produces a correct full result.
6. Address sweep check: in SCAN, monitor the tmpl_sel:tmpl_addr sequence. Expect 0:0..0:15, 1:0 … 9:15 with cap_addr equal to tmpl_addr each cycle, and all addresses 0 in IDLE.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared constants and types for the glyph recognition datapath.
// Row geometry, score width and the matcher FSM state encoding.
package glyph_pkg;
    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;
    localparam int ROW_W   = $clog2(GLYPH_H);
    localparam int POP_W   = $clog2(GLYPH_W) + 1;
    localparam int SCORE_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/glyph_row_match16.sv
// Purpose: count pixels that agree between two 16-pixel rows (XNOR + popcount).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module row_match16
    import glyph_pkg::*;
(
    input  logic [0:GLYPH_W-1] i_a,
    input  logic [0:GLYPH_W-1] i_b,
    output logic [POP_W-1:0]   o_pop
);
    logic [0:GLYPH_W-1] w_match;

    assign w_match = ~(i_a ^ i_b);

    always_comb begin
        o_pop = '0;
        for (int i = 0; i < GLYPH_W; i++) begin
            o_pop = o_pop + POP_W'(w_match[i]);
        end
    end
endmodule

// File: rtl/glyph_matcher.sv
// Purpose: sweep captured bitmap against every digit template, report best match.
// Latency: done pulses 16*NUM_TMPL+1 cycles after the accepted start.
// Backpressure: none; start is ignored unless IDLE, results hold until next done.
module glyph_matcher
    import glyph_pkg::*;
#(
    parameter int NUM_TMPL  = 10,
    parameter int MIN_SCORE = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ROW_W-1:0]   cap_addr,
    input  logic [0:GLYPH_W-1] cap_row,
    output logic [3:0]         tmpl_sel,
    output logic [ROW_W-1:0]   tmpl_addr,
    input  logic [0:GLYPH_W-1] tmpl_row,
    output logic               busy,
    output logic               done,
    output logic [3:0]         digit,
    output logic [SCORE_W-1:0] score,
    output logic               valid
);
    localparam logic [SCORE_W-1:0] MIN_S     = SCORE_W'(MIN_SCORE);
    localparam logic [3:0]         LAST_TMPL = 4'(NUM_TMPL - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ROW_W-1:0]     r_row;
    logic [3:0]           r_tmpl;
    logic [SCORE_W-1:0]   r_acc;
    logic [SCORE_W-1:0]   r_best_score;
    logic [3:0]           r_best_idx;
    logic [3:0]           r_digit;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_valid;

    logic [POP_W-1:0]     w_pop;
    logic [SCORE_W-1:0]   w_total;
    logic                 w_last_row;
    logic                 w_last_tmpl;
    logic                 w_better;
    logic [SCORE_W-1:0]   w_best_score_nxt;
    logic [3:0]           w_best_idx_nxt;

    row_match16 u_row_match (
        .i_a   (cap_row),
        .i_b   (tmpl_row),
        .o_pop (w_pop)
    );

    assign w_total          = r_acc + SCORE_W'(w_pop);
    assign w_last_row       = (r_row == ROW_W'(GLYPH_H - 1));
    assign w_last_tmpl      = (r_tmpl == LAST_TMPL);
    // Strict compare: on a tie the earlier (lower) template index is kept.
    assign w_better         = (w_total > r_best_score);
    assign w_best_score_nxt = w_better ? w_total : r_best_score;
    assign w_best_idx_nxt   = w_better ? r_tmpl  : r_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN;
            SCAN:    if (w_last_row && w_last_tmpl) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Counters are cleared on the final row, so addresses sit at 0 outside SCAN.
    // Results are loaded on the way into DONE so they are already valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_tmpl       <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_digit      <= '0;
            r_score      <= '0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row        <= '0;
                        r_tmpl       <= '0;
                        r_acc        <= '0;
                        r_best_score <= '0;
                        r_best_idx   <= '0;
                    end
                end
                SCAN: begin
                    if (!w_last_row) begin
                        r_acc <= w_total;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_acc        <= '0;
                        r_row        <= '0;
                        r_best_score <= w_best_score_nxt;
                        r_best_idx   <= w_best_idx_nxt;
                        if (w_last_tmpl) begin
                            r_tmpl  <= '0;
                            r_digit <= w_best_idx_nxt;
                            r_score <= w_best_score_nxt;
                            r_valid <= (w_best_score_nxt >= MIN_S);
                        end else begin
                            r_tmpl <= r_tmpl + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cap_addr  = r_row;
    assign tmpl_addr = r_row;
    assign tmpl_sel  = r_tmpl;
    assign digit     = r_digit;
    assign score     = r_score;
    assign valid     = r_valid;
endmodule
